// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : delay_pkg
//  Description : Shared types and helpers for the delay-line priming receiver.
//                Holds the receiver state encoding and the drop-counter width
//                function.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_pkg;

    // Receiver operating state: discard stale beats, then forward.
    typedef enum logic [0:0] {
        PRIMING = 1'b0,
        STREAM  = 1'b1
    } state_e;

    // Width of a counter that must reach 'depth'. A zero depth still needs one
    // bit so the counter register is never zero-width.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage : delay_pkg
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Two-entry ready/valid pipeline stage (main + skid register).
//                Downstream is driven straight from the main register, and the
//                upstream ready is registered: it is simply "skid not full".
//                A synchronous clear empties both entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    // upstream side
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    // downstream side
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic               main_v_q, main_v_d;
    logic [width_p-1:0] main_q,   main_d;
    logic               skid_v_q, skid_v_d;
    logic [width_p-1:0] skid_q,   skid_d;
    logic               ready_q,  ready_d;

    logic up_xfer;
    logic down_xfer;

    assign up_xfer   = valid_i  & ready_q;
    assign down_xfer = main_v_q & ready_i;

    // Next-state for both entries. ready_q is low whenever the skid entry is
    // full, so an upstream transfer can never arrive while skid is occupied.
    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;

        if (clear_i) begin
            main_v_d = 1'b0;
            main_d   = '0;
            skid_v_d = 1'b0;
            skid_d   = '0;
        end else if (!main_v_q || down_xfer) begin
            // Main slot frees up this cycle: refill from skid first to keep order.
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = up_xfer;
                if (up_xfer) begin
                    main_d = data_i;
                end
            end
        end else if (up_xfer) begin
            // Main is stalled: the in-flight beat parks in the skid register.
            skid_v_d = 1'b1;
            skid_d   = data_i;
        end

        ready_d = ~skid_v_d;
    end

    // Buffer registers; ready stays low while reset is held.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = main_v_q;
    assign data_o  = main_q;

endmodule : skid_buffer
`default_nettype wire

// File: rtl/delay_prime_rx.sv
`default_nettype none
// ============================================================================
//  Module      : delay_prime_rx
//  Description : Receiver for a delay line that emits delay_p stale beats
//                after reset or flush. In PRIMING every valid beat is accepted
//                and discarded until delay_p have been counted; in STREAM beats
//                are forwarded through a two-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_prime_rx
    import delay_pkg::*;
#(
    parameter int width_p = 8,
    parameter int delay_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i,
    output logic               primed_o
);

    localparam int               CNT_W       = cnt_width(delay_p);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(delay_p);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    // With nothing to discard the receiver starts out already streaming.
    localparam state_e           START_STATE = (delay_p == 0) ? STREAM : PRIMING;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             primed_q;

    logic             sb_ready;
    logic             sb_valid_in;
    logic             up_xfer;

    // The buffer is empty throughout PRIMING, so its registered ready is high
    // there and serves as the upstream ready in both states.
    assign up_xfer     = valid_i & sb_ready;
    assign sb_valid_in = valid_i & (state_q == STREAM) & ~flush_i;
    assign cnt_inc     = cnt_q + CNT_ONE;

    // Priming state machine: counts dropped beats; flush overrides everything.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= START_STATE;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else if (flush_i) begin
            state_q  <= START_STATE;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            case (state_q)
                PRIMING: begin
                    if (up_xfer) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_q  <= STREAM;
                            primed_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // Counter parks at delay_p; primed follows the state.
                    primed_q <= 1'b1;
                end
                default: begin
                    state_q  <= START_STATE;
                    primed_q <= 1'b0;
                end
            endcase
        end
    end

    skid_buffer #(
        .width_p (width_p)
    ) u_skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .valid_i (sb_valid_in),
        .data_i  (data_i),
        .ready_o (sb_ready),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    assign ready_o  = sb_ready;
    assign primed_o = primed_q;

endmodule : delay_prime_rx
`default_nettype wire

// File: tb/tb_delay_prime_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_prime_rx
//  Description : Self-checking bench for delay_prime_rx (delay_p=8 and 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_prime_rx;

    localparam int DELAY = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // delay_p = 8 instance
    logic       rst   = 1'b1;
    logic       flush = 1'b0;
    logic       vin   = 1'b0;
    logic [7:0] din   = '0;
    logic       rdy   = 1'b1;
    logic       ro, vo, po;
    logic [7:0] dout;

    // delay_p = 0 instance
    logic       rst0   = 1'b1;
    logic       flush0 = 1'b0;
    logic       vin0   = 1'b0;
    logic [7:0] din0   = '0;
    logic       rdy0   = 1'b1;
    logic       ro0, vo0, po0;
    logic [7:0] dout0;

    delay_prime_rx #(.width_p(8), .delay_p(DELAY)) dut (
        .clk_i(clk), .reset_i(rst), .flush_i(flush), .valid_i(vin), .data_i(din),
        .ready_o(ro), .valid_o(vo), .data_o(dout), .ready_i(rdy), .primed_o(po)
    );

    delay_prime_rx #(.width_p(8), .delay_p(0)) dut0 (
        .clk_i(clk), .reset_i(rst0), .flush_i(flush0), .valid_i(vin0), .data_i(din0),
        .ready_o(ro0), .valid_o(vo0), .data_o(dout0), .ready_i(rdy0), .primed_o(po0)
    );

    typedef struct packed {
        logic       vin;
        logic [7:0] din;
        logic       rdy;
        logic       flush;
        logic       ev;
        logic [7:0] ed;
        logic       er;
        logic       ep;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic r, input logic f,
                       input logic ev, input logic [7:0] ed, input logic er, input logic ep);
        vec_t t;
        t.vin = v; t.din = d; t.rdy = r; t.flush = f;
        t.ev = ev; t.ed = ed; t.er = er; t.ep = ep;
        vecs.push_back(t);
    endtask

    task automatic reset_dut();
        rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset valid_o",  32'(vo),   32'd0);
        check("reset data_o",   32'(dout), 32'd0);
        check("reset ready_o",  32'(ro),   32'd0);
        check("reset primed_o", 32'(po),   32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         sent;
        int         recv;
        int         cycles;
        logic [7:0] sbq[$];
        logic [7:0] exp_d;

        // ---------------- vector table ----------------
        // Priming: beats 0x00..0x0B, first 8 dropped.
        for (int i = 0; i < 12; i++)
            add(1'b1, 8'(i), 1'b1, 1'b0, (i >= 9), 8'(i - 1), 1'b1, (i >= 8));
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        // Backpressure: 0x10..0x17 with ready_i low for three cycles.
        add(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        add(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1);
        add(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
        add(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        add(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        add(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        add(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1);
        add(1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b1);
        add(1'b1, 8'h15, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1);
        add(1'b1, 8'h16, 1'b1, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1);
        add(1'b1, 8'h17, 1'b1, 1'b0, 1'b1, 8'h16, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        // Flush with two beats buffered, then a flush that carries a transfer.
        add(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        add(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1);
        add(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1);
        add(1'b1, 8'h23, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++)
            add(1'b1, 8'(8'h24 + k), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 8'h2C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h2C, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // ---------------- apply table ----------------
        reset_dut();
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            vin = vecs[i].vin; din = vecs[i].din; rdy = vecs[i].rdy; flush = vecs[i].flush;
            @(negedge clk);
            check($sformatf("row%0d valid_o", i),  32'(vo), 32'(vecs[i].ev));
            check($sformatf("row%0d ready_o", i),  32'(ro), 32'(vecs[i].er));
            check($sformatf("row%0d primed_o", i), 32'(po), 32'(vecs[i].ep));
            if (vecs[i].ev)
                check($sformatf("row%0d data_o", i), 32'(dout), 32'(vecs[i].ed));
        end
        @(posedge clk); #1;
        vin = 1'b0; flush = 1'b0; rdy = 1'b0;

        // ---------------- asynchronous reset mid-stream ----------------
        @(posedge clk); #1;
        vin = 1'b1; din = 8'h55;
        @(posedge clk); #1;
        vin = 1'b0;
        @(negedge clk);
        check("midrst pre valid_o", 32'(vo),   32'd1);
        check("midrst pre data_o",  32'(dout), 32'h55);
        #2 rst = 1'b1;
        #1;
        check("midrst valid_o",  32'(vo),   32'd0);
        check("midrst data_o",   32'(dout), 32'd0);
        check("midrst ready_o",  32'(ro),   32'd0);
        check("midrst primed_o", 32'(po),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            vin = 1'b1; din = 8'(8'h60 + k);
            @(negedge clk);
            check($sformatf("midrst prime%0d ready_o", k), 32'(ro), 32'd1);
            check($sformatf("midrst prime%0d valid_o", k), 32'(vo), 32'd0);
        end
        @(posedge clk); #1;
        vin = 1'b0;
        @(negedge clk);
        check("midrst first valid_o", 32'(vo),   32'd1);
        check("midrst first data_o",  32'(dout), 32'h68);
        check("midrst primed_o",      32'(po),   32'd1);

        // ---------------- delay_p = 0 ----------------
        @(negedge clk);
        check("d0 reset ready_o", 32'(ro0), 32'd0);
        check("d0 reset valid_o", 32'(vo0), 32'd0);
        rst0 = 1'b0;
        @(posedge clk); #1;
        vin0 = 1'b1; din0 = 8'hA5; rdy0 = 1'b1;
        @(negedge clk);
        check("d0 ready_o",  32'(ro0), 32'd1);
        check("d0 primed_o", 32'(po0), 32'd1);
        check("d0 valid_o idle", 32'(vo0), 32'd0);
        @(posedge clk); #1;
        vin0 = 1'b0;
        @(negedge clk);
        check("d0 valid_o", 32'(vo0),   32'd1);
        check("d0 data_o",  32'(dout0), 32'hA5);

        // ---------------- randomized scoreboard ----------------
        reset_dut();
        sent = 0; recv = 0; cycles = 0;
        while (recv < 1000 - DELAY && cycles < 20000) begin
            @(posedge clk); #1;
            vin = (sent < 1000) && ($urandom_range(0, 1) == 1);
            din = 8'($urandom);
            rdy = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            cycles++;
            if (vo && rdy) begin
                if (sbq.size() == 0) begin
                    check("rand unexpected beat", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    exp_d = sbq.pop_front();
                    check($sformatf("rand beat%0d", recv), 32'(dout), 32'(exp_d));
                end
                recv++;
            end
            if (vin && ro) begin
                if (sent >= DELAY) sbq.push_back(din);
                sent++;
            end
        end
        check("rand beats received", 32'(recv), 32'(1000 - DELAY));
        check("rand beats sent",     32'(sent), 32'd1000);
        check("rand leftover",       32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_delay_prime_rx
`default_nettype wire

// File: doc/delay_prime_rx.md
DELAY_PRIME_RX -- requirements
Module: delay_prime_rx

Interface
REQ-001 SHALL have parameter width_p, default 8: data width in bits, legal values 1 and above.
REQ-002 SHALL have parameter delay_p, default 8: stale beats to discard after reset or flush, legal range 0..16.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, all state rising-edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous request to re-enter priming.
REQ-006 SHALL have port valid_i, input, 1 bit: upstream (delay line) beat valid.
REQ-007 SHALL have port data_i, input, width_p bits: upstream beat data.
REQ-008 SHALL have port ready_o, output, 1 bit: upstream may transfer.
REQ-009 SHALL have port valid_o, output, 1 bit: downstream beat valid.
REQ-010 SHALL have port data_o, output, width_p bits: downstream beat data.
REQ-011 SHALL have port ready_i, input, 1 bit: downstream accepts.
REQ-012 SHALL have port primed_o, output, 1 bit: high when in STREAM state.

Function
REQ-013 SHALL count a transfer only on a cycle with valid_i and ready_o both high; downstream likewise with valid_o and ready_i both high.
REQ-014 SHALL implement states PRIMING and STREAM.
REQ-015 SHALL hold ready_o high in PRIMING, accept every valid beat, and discard it without changing valid_o or data_o.
REQ-016 SHALL hold a drop counter of width clog2(delay_p+1), incremented on each PRIMING transfer.
REQ-017 SHALL move PRIMING to STREAM on the transfer that takes the counter to delay_p; that beat is dropped, and primed_o rises the next cycle.
REQ-018 SHALL, for delay_p=0, leave reset directly in STREAM with no beats dropped.
REQ-019 SHALL, in STREAM, forward beats through a 2-entry skid buffer (main and skid register), with ready_o equal to not skid-full, registered.
REQ-020 SHALL give 1-cycle latency in STREAM: a beat accepted into the empty buffer drives valid_o and data_o on the next cycle.
REQ-021 SHALL sustain one beat per cycle when ready_i is held high.
REQ-022 SHALL, when ready_i drops, capture the in-flight beat in the skid register, deassert ready_o the next cycle, and lose or duplicate no beat.
REQ-023 SHALL keep data_o stable while valid_o is high and ready_i is low.
REQ-024 SHALL, with simultaneous upstream and downstream transfers in STREAM, keep occupancy constant and preserve order.
REQ-025 SHALL give flush_i priority over all events: the next cycle is PRIMING, counter 0, both buffer entries invalid, valid_o 0, primed_o 0.
REQ-026 SHALL drop and not count a beat transferred in the same cycle as flush_i.
REQ-027 SHALL hold the counter at delay_p in STREAM; it never wraps.

Reset
REQ-028 SHALL, while reset_i is high, asynchronously force valid_o=0, data_o=0, ready_o=0, primed_o=0, counter=0, and both buffer entries invalid.
REQ-029 SHALL enter PRIMING on reset, or STREAM when delay_p=0.
REQ-030 SHALL raise ready_o on the first clock edge after reset_i deasserts.
REQ-031 SHALL, on reset mid-stream, discard buffered beats with no downstream transfer.

Structure
REQ-032 SHALL place the state enum (PRIMING, STREAM) and the counter-width function in shared package delay_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module skid_buffer (width_p parameter, ready/valid both sides, async reset), reusable elsewhere.

Verification
REQ-034 SHALL test priming with delay_p=8, ready_i=1 and beats 0x00..0x0B: beats 0x00..0x07 are dropped, primed_o rises after the 8th transfer, and data_o emits 0x08..0x0B with 1-cycle latency.
REQ-035 SHALL test backpressure in STREAM by dropping ready_i for 3 cycles while streaming 0x10..0x17: ready_o is low for 2 of those cycles, and the output order is exactly 0x10..0x17 with none missing or repeated.
REQ-036 SHALL test flush by pulsing flush_i with 2 beats buffered and valid_i high: the next cycle has valid_o=0 and primed_o=0, and the next 8 beats plus the flush-cycle beat are dropped.
REQ-037 SHALL test delay_p=0 by sending 0xA5 right after reset: 0xA5 appears on the next cycle and primed_o=1 out of reset.
REQ-038 SHALL test reset mid-stream by asserting reset_i asynchronously between edges with valid_o=1: all outputs go to 0 immediately, and after release 8 beats are dropped.
REQ-039 SHALL run randomized valid_i/ready_i at 50% for 1000 beats against a scoreboard: the output equals the input minus the first delay_p beats, in order.
